// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int MAX_REQ = 8;  // upper bound on requesters
    localparam int GID_W   = 3;  // width of grant_id / round-robin pointer
    localparam int CNT_W   = 8;  // start-timeout counter, TIMEOUT <= 255

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LAUNCH     = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake, transmitter port and status/error signals of the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    import uart_arb_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_en;
    logic               tx_status;
    logic [GID_W-1:0]   grant_id;
    logic               busy;
    logic               err_timeout;
    logic               err_clr;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, tx_status, err_clr,
        output req_ready, tx_data, tx_en, grant_id, busy, err_timeout
    );

    // Requesters + transmitter side
    modport master (
        output req_valid, req_data, tx_status, err_clr,
        input  req_ready, tx_data, tx_en, grant_id, busy, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin picker: first set request after ptr (wrapping), one-hot + index.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [GID_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [GID_W-1:0] idx
);

    // Scan ptr+1 .. ptr+N (mod N); the first valid requester takes the grant.
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = GID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers: round-robin
// grant, one-cycle launch pulse, data held for the frame, start timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              Reset_n,
    uart_tx_arbiter_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GID_W-1:0] ptr_q, ptr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] grant;
    logic [GID_W-1:0] win_idx;
    logic [7:0]       win_byte;
    logic             arb_en;
    logic             accept;
    logic             timeout_hit;

    // Grants only go out while idle and the transmitter is not busy elsewhere.
    assign arb_en      = (state_q == ST_IDLE) && bus.tx_status;
    assign accept      = |grant;
    assign timeout_hit = (state_q == ST_WAIT_START) && bus.tx_status
                         && (cnt_q == CNT_W'(TIMEOUT));

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (grant),
        .idx   (win_idx)
    );

    // State register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: launch, wait for the transmitter to go busy, then idle again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (accept) state_d = ST_LAUNCH;
            ST_LAUNCH:     state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (!bus.tx_status)              state_d = ST_WAIT_DONE;
                else if (cnt_q == CNT_W'(TIMEOUT)) state_d = ST_IDLE;
            end
            ST_WAIT_DONE:  if (bus.tx_status) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Outputs: tx_en is the LAUNCH state itself, the rest come from registers.
    always_comb begin
        bus.req_ready   = grant;
        bus.tx_en       = (state_q == ST_LAUNCH);
        bus.tx_data     = tx_data_q;
        bus.grant_id    = grant_id_q;
        bus.busy        = busy_q;
        bus.err_timeout = err_q;
    end

    // Datapath next values: byte/grant capture, timeout counter, sticky error.
    always_comb begin
        win_byte   = 8'h00;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == GID_W'(i)) win_byte = bus.req_data[8*i +: 8];
        end
        if (accept) begin
            tx_data_d  = win_byte;
            grant_id_d = win_idx;
            ptr_d      = win_idx;
        end
        if (state_q == ST_LAUNCH) begin
            cnt_d = '0;
        end else if ((state_q == ST_WAIT_START) && bus.tx_status
                     && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
        // A timeout in the same cycle as err_clr keeps the flag set.
        if (timeout_hit)      err_d = 1'b1;
        else if (bus.err_clr) err_d = 1'b0;
        else                  err_d = err_q;
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q      <= '0;
            ptr_q      <= GID_W'(N_REQ - 1);
            tx_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

endmodule
